// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: producer-side write controller for an async FIFO.
// 2-entry in-order skid buffer, IDLE/RUN/DRAIN FSM, write and stall counters.
module fifo_wr_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             wr_clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             clr_cnt,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    output logic             s_ready,
    input  logic             fifo_full,
    output logic             fifo_wr_en,
    output logic [WIDTH-1:0] fifo_wr_data,
    output logic             busy,
    output logic [15:0]      wr_count,
    output logic [15:0]      stall_count
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           state, state_nxt;
    logic [1:0]       occ, occ_pop, occ_nxt;
    logic [WIDTH-1:0] head, tail, head_nxt, tail_nxt;
    logic             acc, stall;

    assign busy         = state != IDLE;
    assign s_ready      = (state == RUN) && (occ != 2'd2);
    assign fifo_wr_en   = busy && (occ != 2'd0) && !fifo_full;
    assign fifo_wr_data = head;
    assign acc          = s_valid && s_ready;
    assign stall        = busy && (occ != 2'd0) && fifo_full;

    // Pop first, then the accepted word lands at the post-pop occupancy slot.
    always_comb begin
        occ_pop  = occ - {1'b0, fifo_wr_en};
        occ_nxt  = occ_pop + {1'b0, acc};
        head_nxt = fifo_wr_en ? tail : head;
        tail_nxt = tail;
        if (acc && occ_pop == 2'd0) head_nxt = s_data;
        if (acc && occ_pop == 2'd1) tail_nxt = s_data;
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = en ? RUN : IDLE;
            RUN:     state_nxt = en ? RUN : DRAIN;
            DRAIN:   state_nxt = en ? RUN : (occ_nxt == 2'd0 ? IDLE : DRAIN);
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wr_clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            occ         <= '0;
            head        <= '0;
            tail        <= '0;
            wr_count    <= '0;
            stall_count <= '0;
        end else begin
            state       <= state_nxt;
            occ         <= occ_nxt;
            head        <= head_nxt;
            tail        <= tail_nxt;
            wr_count    <= clr_cnt ? 16'd0 : wr_count + 16'(fifo_wr_en);
            stall_count <= clr_cnt ? 16'd0 : stall_count + 16'(stall && stall_count != 16'hFFFF);
        end
    end
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl: vector table, directed corner sequences and a randomized run
// checked against a queue-based reference model of the write controller.
module tb_fifo_wr_ctrl;
    logic        wr_clk = 1'b0;
    logic        rstn, en, clr_cnt, s_valid, fifo_full;
    logic [7:0]  s_data;
    logic        s_ready, fifo_wr_en, busy;
    logic [7:0]  fifo_wr_data;
    logic [15:0] wr_count, stall_count;

    fifo_wr_ctrl #(.WIDTH(8)) dut (
        .wr_clk(wr_clk), .rstn(rstn), .en(en), .clr_cnt(clr_cnt),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .busy(busy), .wr_count(wr_count), .stall_count(stall_count)
    );

    always #5 wr_clk = ~wr_clk;

    typedef struct {
        logic       en, sv;
        logic [7:0] sd;
        logic       ff, rdy, wen;
        logic [7:0] wd;
        logic       bsy;
        logic [15:0] wc;
    } vec_t;
    vec_t tbl[8];

    // Reference model: pending words as a queue, mode 0=idle 1=running 2=draining.
    int          q[$];
    int          mode;
    logic [15:0] wc, sc;
    int          checks = 0, failures = 0, nwr = 0, nacc = 0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", n, a, e, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mode = 0;
        wc = '0;
        sc = '0;
    endtask

    // Compare every output against the model, take one edge, advance the model.
    task automatic step();
        bit e_rdy, e_wen, e_busy, e_acc;
        int pend;
        #1;
        pend   = q.size();
        e_busy = mode != 0;
        e_rdy  = mode == 1 && pend < 2;
        e_wen  = e_busy && pend > 0 && !fifo_full;
        e_acc  = s_valid && e_rdy;
        chk("s_ready", s_ready, e_rdy);
        chk("fifo_wr_en", fifo_wr_en, e_wen);
        chk("busy", busy, e_busy);
        chk("wr_count", wr_count, wc);
        chk("stall_count", stall_count, sc);
        if (e_wen) chk("fifo_wr_data", fifo_wr_data, q[0]);
        if (fifo_wr_en === 1'b1) nwr++;
        if (e_acc) nacc++;
        @(posedge wr_clk);
        if (e_wen) void'(q.pop_front());
        if (e_acc) q.push_back(int'(s_data));
        if (clr_cnt) begin
            wc = '0;
            sc = '0;
        end else begin
            wc = wc + (e_wen ? 16'd1 : 16'd0);
            if (e_busy && pend > 0 && fifo_full && sc != 16'hFFFF) sc = sc + 16'd1;
        end
        if (mode == 0) mode = en ? 1 : 0;
        else if (mode == 1) mode = en ? 1 : 2;
        else mode = en ? 1 : (q.size() == 0 ? 0 : 2);
        #1;
    endtask

    task automatic chk_reset_outputs(input string n);
        chk({n, "_s_ready"}, s_ready, 0);
        chk({n, "_wr_en"}, fifo_wr_en, 0);
        chk({n, "_wr_data"}, fifo_wr_data, 0);
        chk({n, "_busy"}, busy, 0);
        chk({n, "_wr_count"}, wr_count, 0);
        chk({n, "_stall_count"}, stall_count, 0);
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0};
        tbl[1] = '{1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'd0};
        tbl[2] = '{1'b1, 1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 8'h01, 1'b1, 16'd0};
        tbl[3] = '{1'b1, 1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 8'h02, 1'b1, 16'd1};
        tbl[4] = '{1'b1, 1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 8'h03, 1'b1, 16'd2};
        tbl[5] = '{1'b1, 1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 8'h04, 1'b1, 16'd3};
        tbl[6] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h05, 1'b1, 16'd4};
        tbl[7] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'd5};

        rstn = 1'b0; en = 1'b0; clr_cnt = 1'b0; s_valid = 1'b0; s_data = '0; fifo_full = 1'b0;
        model_reset();
        #2;
        chk_reset_outputs("reset");
        #10 rstn = 1'b1;
        @(posedge wr_clk);
        #1;

        // Streaming 0x01..0x05 with one-cycle latency
        for (int i = 0; i < 8; i++) begin
            en = tbl[i].en; s_valid = tbl[i].sv; s_data = tbl[i].sd; fifo_full = tbl[i].ff;
            #1;
            chk($sformatf("vec%0d_s_ready", i), s_ready, tbl[i].rdy);
            chk($sformatf("vec%0d_wr_en", i), fifo_wr_en, tbl[i].wen);
            if (tbl[i].wen) chk($sformatf("vec%0d_wr_data", i), fifo_wr_data, tbl[i].wd);
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].bsy);
            chk($sformatf("vec%0d_wr_count", i), wr_count, tbl[i].wc);
            step();
        end

        // Fill under fifo_full, stall for 10 cycles, then release
        clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
        fifo_full = 1'b1; s_valid = 1'b1; s_data = 8'hA1; step();
        s_data = 8'hA2; step();
        s_valid = 1'b0;
        repeat (9) step();
        chk("full_stall_count", stall_count, 16'd10);
        chk("full_s_ready", s_ready, 0);
        chk("full_wr_en", fifo_wr_en, 0);
        fifo_full = 1'b0;
        #1;
        chk("release_wr_en0", fifo_wr_en, 1);
        chk("release_data0", fifo_wr_data, 8'hA1);
        step();
        chk("release_wr_en1", fifo_wr_en, 1);
        chk("release_data1", fifo_wr_data, 8'hA2);
        step();
        chk("release_wr_count", wr_count, 16'd2);

        // Drop en with both entries held
        fifo_full = 1'b1; s_valid = 1'b1; s_data = 8'h11; step();
        s_data = 8'h22; step();
        s_valid = 1'b0; en = 1'b0; fifo_full = 1'b0;
        #1;
        chk("drain_s_ready", s_ready, 0);
        chk("drain_data0", fifo_wr_data, 8'h11);
        step();
        chk("drain_busy_mid", busy, 1);
        chk("drain_s_ready_mid", s_ready, 0);
        chk("drain_data1", fifo_wr_data, 8'h22);
        step();
        chk("drain_busy_end", busy, 0);

        // wr_count wrap and clear priority
        en = 1'b1; clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 70000 && wc != 16'hFFFF; i++) begin
            s_data = 8'(i);
            step();
        end
        chk("wrap_pre", wr_count, 16'hFFFF);
        s_data = 8'h3C; step();
        chk("wrap_post", wr_count, 16'h0000);
        step();
        clr_cnt = 1'b1;
        #1;
        chk("clr_same_cycle_wr_en", fifo_wr_en, 1);
        step();
        clr_cnt = 1'b0;
        chk("clr_same_cycle_count", wr_count, 16'h0000);
        s_valid = 1'b0;
        repeat (2) step();

        // Asynchronous reset with two entries buffered
        fifo_full = 1'b1; s_valid = 1'b1; s_data = 8'h5A; step();
        s_data = 8'h5B; step();
        s_valid = 1'b0;
        rstn = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        model_reset();
        #2 rstn = 1'b1;
        en = 1'b0; fifo_full = 1'b0;
        @(posedge wr_clk);
        #1;
        repeat (3) step();
        en = 1'b1;
        repeat (3) step();
        chk("midreset_no_write", wr_count, 16'd0);

        // Randomized traffic against the reference model
        nwr = 0; nacc = 0;
        for (int i = 0; i < 10000; i++) begin
            en        = $urandom_range(0, 19) != 0;
            s_valid   = 1'($urandom_range(0, 1));
            fifo_full = $urandom_range(0, 9) < 3;
            clr_cnt   = $urandom_range(0, 199) == 0;
            s_data    = 8'($urandom);
            step();
        end
        en = 1'b1; s_valid = 1'b0; fifo_full = 1'b0; clr_cnt = 1'b0;
        repeat (4) step();
        chk("random_written_vs_accepted", nwr, nacc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo_wr_ctrl.md
FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data width in bits; it SHALL match the downstream async FIFO write data width.
REQ-002 SHALL have port wr_clk  input  1  write-domain clock; all state updates on its rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port en  input  1  stream enable; 1 = accept and forward, 0 = stop accepting and drain.
REQ-005 SHALL have port clr_cnt  input  1  synchronous clear of wr_count and stall_count.
REQ-006 SHALL have port s_valid  input  1  producer data valid.
REQ-007 SHALL have port s_data  input  WIDTH  producer data.
REQ-008 SHALL have port s_ready  output  1  block can accept s_data this cycle.
REQ-009 SHALL have port fifo_full  input  1  full flag from downstream async FIFO (wr_clk domain).
REQ-010 SHALL have port fifo_wr_en  output  1  write strobe to FIFO.
REQ-011 SHALL have port fifo_wr_data  output  WIDTH  write data to FIFO.
REQ-012 SHALL have port busy  output  1  1 when FSM not IDLE.
REQ-013 SHALL have port wr_count  output  16  number of FIFO writes issued, wraps modulo 2^16.
REQ-014 SHALL have port stall_count  output  16  cycles with data pending and fifo_full=1, saturates at 0xFFFF.

Function
REQ-015 SHALL hold a 2-entry in-order skid buffer (head, tail) with occupancy occ in {0,1,2}.
REQ-016 SHALL implement FSM states IDLE, RUN, DRAIN: IDLE->RUN when en=1; RUN->DRAIN when en=0; DRAIN->IDLE when occ=0 (including the cycle the last entry is written); DRAIN->RUN when en=1.
REQ-017 SHALL drive s_ready = (state==RUN) && (occ<2), decoded from registered state only.
REQ-018 SHALL accept s_data at a rising edge when s_valid && s_ready; accepted data SHALL be stored at position occ (after any simultaneous write pop).
REQ-019 SHALL drive fifo_wr_en = (state!=IDLE) && (occ!=0) && !fifo_full, combinational from registered state/occ and fifo_full.
REQ-020 SHALL drive fifo_wr_data = head entry at all times; when fifo_wr_en=1 the head SHALL be popped at that edge and tail SHALL shift to head.
REQ-021 Latency: data accepted at edge N SHALL appear on fifo_wr_data after edge N and be written at edge N+1 when occ was 0 and fifo_full=0.
REQ-022 Simultaneous accept and write SHALL keep occ unchanged and preserve order; no data SHALL be lost, duplicated or reordered.
REQ-023 fifo_full=1 SHALL hold fifo_wr_en=0 and the buffer contents; write resumes on the first cycle fifo_full=0.
REQ-024 With occ=2, s_ready SHALL be 0; with fifo_full stuck at 1 the block SHALL back-pressure indefinitely without overflow.
REQ-025 wr_count SHALL increment by 1 on every edge where fifo_wr_en=1; 0xFFFF+1 SHALL wrap to 0x0000.
REQ-026 stall_count SHALL increment on every edge where state!=IDLE, occ!=0 and fifo_full=1, and SHALL hold at 0xFFFF.
REQ-027 clr_cnt=1 SHALL set both counters to 0 at the next edge, taking priority over a same-cycle increment.
REQ-028 busy SHALL equal (state!=IDLE).

Reset
REQ-029 On rstn=0, asynchronously: state=IDLE, occ=0, buffer entries=0, wr_count=0, stall_count=0; thus s_ready=0, fifo_wr_en=0, fifo_wr_data=0, busy=0.
REQ-030 Reset asserted mid-transfer SHALL discard buffered data; no write SHALL be issued until after rstn deasserts and en=1.

Verification
REQ-031 Reset, en=1, s_valid=1 with s_data 0x01..0x05, fifo_full=0 -> fifo_wr_data 0x01..0x05 written in order, one per cycle, 1-cycle latency, wr_count=5.
REQ-032 Fill with 0xA1,0xA2 while fifo_full=1 for 10 cycles -> occ=2, s_ready=0, fifo_wr_en=0, stall_count=10; release -> 0xA1 then 0xA2 written.
REQ-033 en dropped with occ=2 (0x11,0x22), fifo_full=0 -> s_ready=0, state DRAIN, 0x11 and 0x22 written, busy=0 two cycles later.
REQ-034 Preload wr_count 0xFFFF via 65535 writes, one more write -> wr_count=0x0000; clr_cnt with simultaneous write -> wr_count=0.
REQ-035 rstn pulsed low with occ=2 -> outputs immediately at reset values, previously buffered data never written.
REQ-036 Random s_valid and fifo_full toggling for 10000 cycles with scoreboard -> write sequence equals accepted sequence exactly.
